timing_phase_decoder: RTL
=========================

Name: timing_phase_decoder

Overview:
- Receive-side consumer of the 4-bit timing counter outputs (count_0..count_3).
- Samples the counter on clk and checks that it advances by exactly +1 (mod 16) every cycle.
- Acquires lock after a run of good increments; while locked, emits a registered one-hot phase vector and a frame-start strobe.
- Counts sequence faults (skip, stall, unexpected reset) for the timing module's status logic.

Parameters:
- LOCK_COUNT, 4: consecutive correct increments needed to enter LOCKED (legal range 1..15).
- ERR_CNT_W, 8: width of the saturating fault counter.

Ports:
- clk  input  1  system clock; same clock as the counter.
- reset  input  1  asynchronous, active-high reset.
- count_0  input  1  counter bit 0 (LSB).
- count_1  input  1  counter bit 1.
- count_2  input  1  counter bit 2.
- count_3  input  1  counter bit 3 (MSB).
- clear_err  input  1  synchronous clear of err_count, one-cycle pulse.
- phase_onehot  output  16  one-hot decode of the sampled count; all-zero unless locked.
- frame_start  output  1  one-cycle pulse when locked and the sampled count equals 0.
- locked  output  1  high while the FSM is in LOCKED.
- err_pulse  output  1  one-cycle pulse on each fault detected while LOCKED.
- err_count  output  ERR_CNT_W  saturating count of faults.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; sample registers 0; good_run 0.
- Reset is honoured at any time, including mid-run: it returns everything to the reset state immediately. The next lock needs a full reacquire.
- Input stage:
  - {count_3..count_0} is registered into samp on every clk.
  - prev holds the previous samp.
  - Expected value is prev+1 mod 16; 15 -> 0 is a correct increment.
- Output timing:
  - All outputs are registered from the samp/prev comparison.
  - Latency from a count input change to phase_onehot/frame_start is 2 clk edges.
- FSM states:
  - IDLE: the first sample after reset is captured as the reference, then go to ACQUIRE with good_run=0.
  - ACQUIRE:
    - If samp==expected: good_run++.
    - When good_run reaches LOCK_COUNT: go to LOCKED, and locked rises on that same edge.
    - On a mismatch: good_run=0 and stay in ACQUIRE. There is no err_pulse and no err_count change.
  - LOCKED:
    - If samp==expected: stay in LOCKED.
    - A mismatch of any kind (skip, stall with samp==prev, or jump to 0 from an upstream counter reset) is a fault:
      - go to FAULT;
      - locked falls;
      - err_pulse=1 for one cycle;
      - err_count++.
  - FAULT: unconditional one-cycle state. Go to ACQUIRE with good_run=0; the current samp becomes the new reference.
- phase_onehot: bit[samp] is set when the next state is LOCKED, otherwise all zeros. It is never multi-hot.
- frame_start: asserted when the next state is LOCKED and samp==0.
- err_count:
  - Saturates at 2^ERR_CNT_W-1 with no wrap.
  - clear_err sets it to 0.
  - If clear_err and a fault occur in the same cycle, clear wins, err_count=0, and err_pulse still fires.
- A fault on the very cycle lock would be reached: the mismatch takes priority and the FSM stays in ACQUIRE.

Optional Feature:
- Macro: TIMING_PHASE_SYNC_EN.
- Defined:
  - A 2-flop synchronizer is inserted ahead of samp on all four count bits, for use when the counter runs on an unrelated clock.
  - Latency becomes 4 clk edges.
  - Multi-bit skew can cause transient faults; this is accepted and flagged through err_count.
- Undefined: count bits feed samp directly, with latency 2.

Decomposition:
- Shared package timing_pkg:
  - CNT_W=4;
  - NUM_PHASES=16;
  - FSM state enum (IDLE, ACQUIRE, LOCKED, FAULT).
- Sub-module timing_input_sync: a 2-flop, 4-bit synchronizer, instantiated only under TIMING_PHASE_SYNC_EN.

Test Plan:
- Lock acquisition (LOCK_COUNT=4, macro off):
  - Stimulus: release reset, drive counter 0,1,2,...
  - Required: locked rises at edge 6 after the first sample; phase_onehot is one-hot tracking count with a 2-cycle lag; frame_start pulses once per 16 cycles when 0 is sampled.
- Skip fault:
  - Stimulus: while locked, drive sequence 5,6,8.
  - Required: one err_pulse; err_count 0->1; locked falls; phase_onehot goes to 0; relock after 4 good increments from 8.
- Stall and counter reset:
  - Stimulus while locked: hold count at 9 for 2 cycles, then relock and jump 12->0.
  - Required: each event produces exactly 1 fault, giving err_count=2.
- Saturation and clear:
  - Stimulus: ERR_CNT_W=2, inject 5 faults; then assert clear_err on the same cycle as a sixth fault.
  - Required: err_count stops at 3 after the 5 faults; on the sixth, err_count=0 and err_pulse=1.
- Mid-run reset:
  - Stimulus: assert reset asynchronously between edges while locked.
  - Required: all outputs go to 0 immediately; after release, no lock before LOCK_COUNT good increments.
- Macro on:
  - Stimulus: repeat the lock acquisition scenario with TIMING_PHASE_SYNC_EN defined.
  - Required: same behaviour as the macro-off run, shifted by 2 extra cycles (locked at edge 8).

Source files
------------

// File: rtl/timing_pkg.sv
// Shared definitions for the timing phase decoder slice: counter width,
// phase count and the lock FSM state encoding.
package timing_pkg;

    localparam int CNT_W      = 4;
    localparam int NUM_PHASES = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        FAULT   = 2'd3
    } state_t;

    // One-hot decode of a counter value into the phase vector.
    function automatic logic [NUM_PHASES-1:0] phase_decode(input logic [CNT_W-1:0] v);
        logic [NUM_PHASES-1:0] r;
        r    = '0;
        r[v] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/timing_phase_decoder_if.sv
// Bus between the timing counter / status logic and the phase decoder.
// master: counter side (drives count bits and clear_err).
// slave:  decoder side (drives phase, strobe, lock and fault status).
interface timing_phase_decoder_if
    import timing_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) ();

    logic                  count_0;
    logic                  count_1;
    logic                  count_2;
    logic                  count_3;
    logic                  clear_err;
    logic [NUM_PHASES-1:0] phase_onehot;
    logic                  frame_start;
    logic                  locked;
    logic                  err_pulse;
    logic [ERR_CNT_W-1:0]  err_count;

    modport master (
        output count_0, count_1, count_2, count_3, clear_err,
        input  phase_onehot, frame_start, locked, err_pulse, err_count
    );

    modport slave (
        input  count_0, count_1, count_2, count_3, clear_err,
        output phase_onehot, frame_start, locked, err_pulse, err_count
    );

endinterface

// File: rtl/timing_input_sync.sv
// Two-flop synchronizer for the counter bits when the counter lives in an
// unrelated clock domain. Bits are synchronized independently, so a
// multi-bit transition may land skewed; the decoder treats that as an
// ordinary sequence fault.
module timing_input_sync
    import timing_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [1:0][W-1:0] sync_q;

    // Shift the raw bits through two flop stages.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= d;
            sync_q[1] <= sync_q[0];
        end
    end

    assign q = sync_q[1];

endmodule

// File: rtl/timing_phase_decoder.sv
// Receive-side timing phase decoder.
// Samples the 4-bit timing counter every clk, checks it advances by +1
// (mod 16), locks after LOCK_COUNT good increments and then emits a one-hot
// phase vector and a frame-start strobe. Faults seen while locked are
// pulsed and counted in a saturating counter.
// Build option: TIMING_PHASE_SYNC_EN inserts a 2-flop synchronizer ahead
// of the sample register (count-to-output latency 4 instead of 2 edges).
module timing_phase_decoder
    import timing_pkg::*;
#(
    parameter int LOCK_COUNT = 4,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    timing_phase_decoder_if.slave bus
);

    localparam logic [CNT_W-1:0]     LOCK_CNT = CNT_W'(LOCK_COUNT);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX  = '1;

    logic [CNT_W-1:0] cnt_raw;
    logic [CNT_W-1:0] cnt_in;

    assign cnt_raw = {bus.count_3, bus.count_2, bus.count_1, bus.count_0};

`ifdef TIMING_PHASE_SYNC_EN
    // samp becomes meaningful three edges after reset release
    localparam int STAGES = 3;

    timing_input_sync #(
        .W (CNT_W)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (cnt_raw),
        .q     (cnt_in)
    );
`else
    // samp becomes meaningful one edge after reset release
    localparam int STAGES = 1;

    assign cnt_in = cnt_raw;
`endif

    logic [CNT_W-1:0]      samp;
    logic [CNT_W-1:0]      prev;
    logic [STAGES:1]       vld_pipe;
    logic                  samp_vld;

    state_t                state;
    logic [CNT_W-1:0]      good_run;
    logic [CNT_W-1:0]      good_inc;
    logic [CNT_W-1:0]      expected;
    logic                  match;
    logic                  lock_next;
    logic                  fault;

    logic                  locked_q;
    logic [NUM_PHASES-1:0] phase_q;
    logic                  frame_start_q;
    logic                  err_pulse_q;
    logic [ERR_CNT_W-1:0]  err_count_q;

    // Input stage: register the counter and keep the previous sample.
    // vld_pipe tracks when samp first holds a real counter value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            samp     <= '0;
            prev     <= '0;
            vld_pipe <= '0;
        end else begin
            samp        <= cnt_in;
            prev        <= samp;
            vld_pipe[1] <= 1'b1;
            for (int i = 2; i <= STAGES; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
            end
        end
    end

    assign samp_vld = vld_pipe[STAGES];
    assign expected = prev + 1'b1;
    assign match    = (samp == expected);
    assign good_inc = good_run + 1'b1;

    // Next state is LOCKED either by completing the acquire run or by a
    // good increment while already locked; a mismatch always wins.
    assign lock_next = match &&
                       (((state == ACQUIRE) && (good_inc == LOCK_CNT)) ||
                        (state == LOCKED));
    assign fault     = (state == LOCKED) && !match;

    // Lock FSM with registered phase, strobe and fault status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            good_run      <= '0;
            locked_q      <= 1'b0;
            phase_q       <= '0;
            frame_start_q <= 1'b0;
            err_pulse_q   <= 1'b0;
            err_count_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // first valid sample becomes the reference via prev
                    if (samp_vld) begin
                        state    <= ACQUIRE;
                        good_run <= '0;
                    end
                end
                ACQUIRE: begin
                    if (!match) begin
                        good_run <= '0;
                    end else if (good_inc == LOCK_CNT) begin
                        state    <= LOCKED;
                        good_run <= '0;
                    end else begin
                        good_run <= good_inc;
                    end
                end
                LOCKED: begin
                    if (!match) begin
                        state <= FAULT;
                    end
                end
                FAULT: begin
                    // one dead cycle; the sample present now seeds prev
                    state    <= ACQUIRE;
                    good_run <= '0;
                end
                default: begin
                    state    <= IDLE;
                    good_run <= '0;
                end
            endcase

            locked_q      <= lock_next;
            phase_q       <= lock_next ? phase_decode(samp) : '0;
            frame_start_q <= lock_next && (samp == '0);
            err_pulse_q   <= fault;

            // clear has priority over a coincident fault
            if (bus.clear_err) begin
                err_count_q <= '0;
            end else if (fault && (err_count_q != ERR_MAX)) begin
                err_count_q <= err_count_q + 1'b1;
            end
        end
    end

    assign bus.phase_onehot = phase_q;
    assign bus.frame_start  = frame_start_q;
    assign bus.locked       = locked_q;
    assign bus.err_pulse    = err_pulse_q;
    assign bus.err_count    = err_count_q;

    // Output sanity: never multi-hot, strobe only while locked.
    a_phase_onehot0 : assert property (@(posedge clk) disable iff (reset)
        $onehot0(phase_q));
    a_frame_in_lock : assert property (@(posedge clk) disable iff (reset)
        frame_start_q |-> locked_q);

endmodule
